// File: rtl/la_iopwrseq.sv
// IO-ring power sequencer: waits for good supplies, settles, enables ring sides one at a
// time, releases isolation, and ramps down in reverse order or drops to a safe state.
module la_iopwrseq #(
    parameter int NSIDE  = 4,
    parameter int SETTLE = 64,
    parameter int STEP   = 16,
    parameter int CW     = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic             vddio_ok,
    input  logic             vdd_ok,
    output logic [NSIDE-1:0] side_en,
    output logic             iso,
    output logic             ready,
    output logic             busy,
    output logic             fault
);

    localparam int IW = (NSIDE > 1) ? $clog2(NSIDE) : 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_WAIT,
        S_SETTLE,
        S_RAMPUP,
        S_RELEASE,
        S_ON,
        S_RAMPDN,
        S_FAULT
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [NSIDE-1:0]  side_nxt;
    logic [1:0]        vddio_sync, vdd_sync;
    logic              pgood;
    logic              go_down, go_fault;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, regardless of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vddio_sync <= '0;
            vdd_sync   <= '0;
        end else begin
            vddio_sync <= {vddio_sync[0], vddio_ok};
            vdd_sync   <= {vdd_sync[0], vdd_ok};
        end
    end

    assign pgood = vddio_sync[1] & vdd_sync[1];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        side_nxt  = side_en;
        go_down   = 1'b0;
        go_fault  = 1'b0;

        unique case (state)
            S_OFF: begin
                cnt_nxt = '0;
                if (en) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                cnt_nxt = '0;
                if (!en)        state_nxt = S_OFF;
                else if (pgood) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (!en) begin
                    state_nxt = S_OFF;
                    cnt_nxt   = '0;
                end else if (!pgood) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(SETTLE - 1)) begin
                    state_nxt   = S_RAMPUP;
                    cnt_nxt     = '0;
                    idx_nxt     = '0;
                    side_nxt[0] = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RAMPUP: begin
                if (!pgood)   go_fault = 1'b1;
                else if (!en) go_down  = 1'b1;
                else if (cnt == CW'(STEP - 1)) begin
                    cnt_nxt = '0;
                    if (idx == IW'(NSIDE - 1)) begin
                        state_nxt = S_RELEASE;
                    end else begin
                        idx_nxt           = idx + IW'(1);
                        side_nxt[idx_nxt] = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RELEASE, S_ON: begin
                if (!pgood)                 go_fault  = 1'b1;
                else if (!en)               go_down   = 1'b1;
                else if (state == S_RELEASE) state_nxt = S_ON;
            end
            S_RAMPDN: begin
                if (!pgood)                    go_fault = 1'b1;
                else if (cnt == CW'(STEP - 1)) go_down  = 1'b1;
                else                           cnt_nxt  = cnt + CW'(1);
            end
            S_FAULT: begin
                if (!en) state_nxt = S_OFF;
            end
            default: state_nxt = S_OFF;
        endcase

        // idx always points at the highest enabled side, so ramp-down clears it and walks down.
        if (go_fault) begin
            state_nxt = S_FAULT;
            side_nxt  = '0;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else if (go_down) begin
            side_nxt[idx] = 1'b0;
            cnt_nxt       = '0;
            if (idx == '0) begin
                state_nxt = S_OFF;
            end else begin
                state_nxt = S_RAMPDN;
                idx_nxt   = idx - IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= S_OFF;
            cnt     <= '0;
            idx     <= '0;
            side_en <= '0;
            iso     <= 1'b1;
            ready   <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            side_en <= side_nxt;
            iso     <= !(state_nxt inside {S_RELEASE, S_ON});
            ready   <= (state_nxt == S_ON);
            busy    <= (state_nxt inside {S_WAIT, S_SETTLE, S_RAMPUP, S_RELEASE, S_RAMPDN});
            fault   <= (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_la_iopwrseq.sv
// Directed bench for la_iopwrseq with NSIDE=4, SETTLE=4, STEP=2.
module tb_la_iopwrseq;

    logic       clk = 1'b0;
    logic       nreset;
    logic       en;
    logic       vddio_ok;
    logic       vdd_ok;
    logic [3:0] side_en;
    logic       iso;
    logic       ready;
    logic       busy;
    logic       fault;

    int tests = 0;
    int fails = 0;

    la_iopwrseq #(.NSIDE(4), .SETTLE(4), .STEP(2), .CW(8)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .en       (en),
        .vddio_ok (vddio_ok),
        .vdd_ok   (vdd_ok),
        .side_en  (side_en),
        .iso      (iso),
        .ready    (ready),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] s, input logic i,
                             input logic r, input logic b, input logic f);
        check({tag, ".side_en"}, 32'(side_en), 32'(s));
        check({tag, ".iso"},     32'(iso),     32'(i));
        check({tag, ".ready"},   32'(ready),   32'(r));
        check({tag, ".busy"},    32'(busy),    32'(b));
        check({tag, ".fault"},   32'(fault),   32'(f));
    endtask

    initial begin
        logic [3:0] exp_side;
        nreset   = 1'b0;
        en       = 1'b0;
        vddio_ok = 1'b1;
        vdd_ok   = 1'b1;
        #12;
        check_out("reset", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        nreset = 1'b1;
        tick(4);
        check_out("idle", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // 1: power-up, ready 15 edges after en is first sampled
        en = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick(1);
            if (e < 6)       exp_side = 4'b0000;
            else if (e < 8)  exp_side = 4'b0001;
            else if (e < 10) exp_side = 4'b0011;
            else if (e < 12) exp_side = 4'b0111;
            else             exp_side = 4'b1111;
            check_out($sformatf("up_e%0d", e), exp_side, (e < 14), (e >= 15), (e < 15), 1'b0);
        end

        // 2: power-down in reverse order
        en = 1'b0;
        tick(1); check_out("dn_e1", 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1); check_out("dn_e2", 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1); check_out("dn_e3", 4'b0011, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(2); check_out("dn_e5", 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(2); check_out("dn_e7", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // 3: core supply dips during settle; settle restarts from scratch
        en = 1'b1;
        tick(2);
        vdd_ok = 1'b0;
        tick(3);
        vdd_ok = 1'b1;
        tick(6); check_out("glitch_e11", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1); check_out("glitch_e12", 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(8); check_out("glitch_e20", 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1); check_out("glitch_e21", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);

        // 4: IO supply loss in ON -> fault after synchronizer delay, sticky until en=0
        vddio_ok = 1'b0;
        tick(2); check_out("loss_e2", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1); check_out("loss_e3", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        vddio_ok = 1'b1;
        tick(5); check_out("fault_hold", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        en = 1'b0;
        tick(1); check_out("fault_clr", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // 5: async reset mid-ramp, then a full sequence with fresh synchronizers
        en = 1'b1;
        tick(8); check_out("rst_pre", 4'b0011, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        nreset = 1'b0;
        #1;
        check_out("rst_async", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        nreset = 1'b1;
        tick(15); check_out("rst_e15", 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1);  check_out("rst_e16", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
